// File: rtl/uart_cmd_parser.sv
// Line-oriented LED command parser between usb_uart's receive and transmit pipelines.
// It echoes each byte, buffers the line, and on CR applies r/g/b/c commands and replies OK, ER or a bare newline.
module uart_cmd_parser #(
    parameter int LINE_MAX = 16
) (
    input  logic       clk_48mhz,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic [2:0] led,
    output logic       cmd_strobe,
    output logic       err_strobe
);
    localparam int LW = $clog2(LINE_MAX + 1);
    localparam int IW = $clog2(LINE_MAX);
    localparam logic [LW-1:0] LEN_MAX = LW'(LINE_MAX);
    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] LF = 8'h0A;

    typedef enum logic [2:0] {RECV, ECHO, SCAN, COMMIT, REPLY} state_t;
    typedef enum logic [1:0] {RPL_NL, RPL_ER, RPL_OK} reply_t;

    // Valid/ready: a byte moves on an edge where valid && ready; tx_valid and tx_data
    // hold until tx_ready is seen, and rx_ready depends on state alone.
    state_t        state;
    reply_t        reply_kind;
    logic [7:0]    cur;
    logic [7:0]    line_buf [LINE_MAX];
    logic [LW-1:0] len;
    logic [LW-1:0] idx;
    logic          ovf;
    logic          bad;
    logic [2:0]    shadow;
    logic [2:0]    ridx;

    function automatic logic [7:0] reply_byte(reply_t kind, logic [2:0] i);
        case (i)
            3'd0:    reply_byte = LF;
            3'd1:    reply_byte = (kind == RPL_OK) ? 8'h4F : 8'h45;
            3'd2:    reply_byte = (kind == RPL_OK) ? 8'h4B : 8'h52;
            3'd3:    reply_byte = CR;
            default: reply_byte = LF;
        endcase
    endfunction

    assign rx_ready = (state == RECV);

    always_ff @(posedge clk_48mhz) begin
        if (reset) begin
            state      <= RECV;
            reply_kind <= RPL_NL;
            cur        <= 8'h00;
            len        <= '0;
            idx        <= '0;
            ovf        <= 1'b0;
            bad        <= 1'b0;
            shadow     <= 3'b000;
            ridx       <= 3'd0;
            led        <= 3'b000;
            tx_data    <= 8'h00;
            tx_valid   <= 1'b0;
            cmd_strobe <= 1'b0;
            err_strobe <= 1'b0;
        end else begin
            cmd_strobe <= 1'b0;
            err_strobe <= 1'b0;
            case (state)
                RECV: begin
                    if (rx_valid) begin
                        cur <= rx_data;
                        if (rx_data != LF) begin
                            state    <= ECHO;
                            tx_valid <= 1'b1;
                            tx_data  <= rx_data;
                            if (rx_data != CR) begin
                                if (len < LEN_MAX) begin
                                    line_buf[len[IW-1:0]] <= rx_data;
                                    len <= len + LW'(1);
                                end else begin
                                    ovf <= 1'b1;
                                end
                            end
                        end
                    end
                end
                ECHO: begin
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        if (cur == CR) begin
                            state  <= SCAN;
                            idx    <= '0;
                            shadow <= led;
                        end else begin
                            state <= RECV;
                        end
                    end
                end
                SCAN: begin
                    if (idx == len) begin
                        state <= COMMIT;
                    end else begin
                        idx <= idx + LW'(1);
                        case (line_buf[idx[IW-1:0]])
                            8'h72:   shadow[2] <= ~shadow[2];
                            8'h67:   shadow[1] <= ~shadow[1];
                            8'h62:   shadow[0] <= ~shadow[0];
                            8'h63:   shadow    <= 3'b000;
                            default: bad       <= 1'b1;
                        endcase
                    end
                end
                COMMIT: begin
                    if (len == '0 && !ovf) begin
                        reply_kind <= RPL_NL;
                    end else if (ovf || bad) begin
                        reply_kind <= RPL_ER;
                        err_strobe <= 1'b1;
                    end else begin
                        reply_kind <= RPL_OK;
                        led        <= shadow;
                        cmd_strobe <= 1'b1;
                    end
                    len      <= '0;
                    ovf      <= 1'b0;
                    bad      <= 1'b0;
                    ridx     <= 3'd0;
                    tx_valid <= 1'b1;
                    tx_data  <= LF;
                    state    <= REPLY;
                end
                REPLY: begin
                    if (tx_valid && tx_ready) begin
                        // A bare-newline reply is one byte long; OK/ER replies are five.
                        if ((reply_kind == RPL_NL) || (ridx == 3'd4)) begin
                            tx_valid <= 1'b0;
                            state    <= RECV;
                        end else begin
                            ridx    <= ridx + 3'd1;
                            tx_data <= reply_byte(reply_kind, ridx + 3'd1);
                        end
                    end
                end
                default: state <= RECV;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_cmd_parser.sv
// Self-checking bench for uart_cmd_parser: table of command lines with hand-computed LED results,
// plus hand-written back-pressure and mid-reply reset sequences.
module tb_uart_cmd_parser;
  localparam int K_NL = 0;
  localparam int K_ER = 1;
  localparam int K_OK = 2;

  logic       clk_48mhz = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [2:0] led;
  logic       cmd_strobe;
  logic       err_strobe;

  int n_cmp = 0;
  int n_fail = 0;
  int cmd_cnt = 0;
  int err_cnt = 0;
  logic [7:0] exp_q[$];

  typedef struct packed {
    logic [159:0] text;
    logic [4:0]   n;
    logic [2:0]   exp_led;
    logic [1:0]   kind;
  } vec_t;

  vec_t vecs [6];

  uart_cmd_parser #(.LINE_MAX(16)) dut (
    .clk_48mhz(clk_48mhz), .reset(reset),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .led(led), .cmd_strobe(cmd_strobe), .err_strobe(err_strobe)
  );

  // clock / reset
  always #5 clk_48mhz = ~clk_48mhz;

  // scoreboard: every tx handshake must match the head of exp_q
  always @(negedge clk_48mhz) begin
    if (!reset) begin
      if (cmd_strobe) cmd_cnt++;
      if (err_strobe) err_cnt++;
      if (tx_valid && tx_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL tx_unexpected: got %h, expected no byte", tx_data);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (tx_data !== e) begin
            n_fail++;
            $display("FAIL tx_byte: got %h, expected %h", tx_data, e);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // driver: present one byte and hold it until accepted
  task automatic send_byte(input logic [7:0] b);
    bit done = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    for (int t = 0; t < 500 && !done; t++) begin
      @(negedge clk_48mhz);
      if (rx_ready) done = 1;
    end
    @(posedge clk_48mhz);
    #1;
    rx_valid = 1'b0;
    if (!done) begin
      n_cmp++;
      n_fail++;
      $display("FAIL rx_accept_timeout: byte %h not accepted, expected acceptance", b);
    end
  endtask

  task automatic push_reply(input int kind);
    exp_q.push_back(8'h0A);
    if (kind != K_NL) begin
      exp_q.push_back(kind == K_OK ? 8'h4F : 8'h45);
      exp_q.push_back(kind == K_OK ? 8'h4B : 8'h52);
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
    end
  endtask

  task automatic wait_idle(input string name);
    bit done = 0;
    for (int t = 0; t < 1000 && !done; t++) begin
      @(negedge clk_48mhz);
      if (exp_q.size() == 0 && rx_ready) done = 1;
    end
    check({name, "_idle"}, 32'(done), 32'd1);
    @(posedge clk_48mhz);
    #1;
  endtask

  task automatic run_line(input string name, input logic [159:0] text, input int n,
                          input int kind, input logic [2:0] exp_led);
    int c0 = cmd_cnt;
    int e0 = err_cnt;
    for (int j = 0; j < n; j++) begin
      logic [7:0] b;
      b = text[8*(n-1-j) +: 8];
      exp_q.push_back(b);
      send_byte(b);
    end
    exp_q.push_back(8'h0D);
    send_byte(8'h0D);
    push_reply(kind);
    wait_idle(name);
    check({name, "_led"}, 32'(led), 32'(exp_led));
    check({name, "_cmd"}, 32'(cmd_cnt - c0), (kind == K_OK) ? 32'd1 : 32'd0);
    check({name, "_err"}, 32'(err_cnt - e0), (kind == K_ER) ? 32'd1 : 32'd0);
  endtask

  initial begin
    bit ok;
    bit found;
    int c0;
    int e0;
    vecs[0] = '{text: 160'("r"),                 n: 5'd1,  exp_led: 3'b100, kind: 2'(K_OK)};
    vecs[1] = '{text: 160'("gbc b"),             n: 5'd5,  exp_led: 3'b100, kind: 2'(K_ER)};
    vecs[2] = '{text: 160'("gbcb"),              n: 5'd4,  exp_led: 3'b001, kind: 2'(K_OK)};
    vecs[3] = '{text: 160'("ggggggggggggggggg"), n: 5'd17, exp_led: 3'b001, kind: 2'(K_ER)};
    vecs[4] = '{text: 160'("gggggggggggggggg"),  n: 5'd16, exp_led: 3'b001, kind: 2'(K_OK)};
    vecs[5] = '{text: 160'(0),                   n: 5'd0,  exp_led: 3'b001, kind: 2'(K_NL)};

    reset    = 1'b1;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    repeat (3) @(posedge clk_48mhz);
    #1;
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_led", 32'(led), 32'd0);
    check("rst_strobes", 32'({cmd_strobe, err_strobe}), 32'd0);
    check("rst_rx_ready", 32'(rx_ready), 32'd1);
    reset = 1'b0;

    for (int i = 0; i < 6; i++)
      run_line($sformatf("vec%0d", i), vecs[i].text, int'(vecs[i].n), int'(vecs[i].kind), vecs[i].exp_led);

    // LF alone: discarded, no echo, no strobes
    c0 = cmd_cnt;
    e0 = err_cnt;
    send_byte(8'h0A);
    repeat (5) @(posedge clk_48mhz);
    #1;
    check("lf_rx_ready", 32'(rx_ready), 32'd1);
    check("lf_tx_valid", 32'(tx_valid), 32'd0);
    check("lf_strobes", 32'((cmd_cnt - c0) + (err_cnt - e0)), 32'd0);

    // back-pressure during echo of 'b'; 'r' must be held off, then resume without loss
    c0 = cmd_cnt;
    tx_ready = 1'b0;
    exp_q.push_back(8'h62);
    send_byte(8'h62);
    rx_data  = 8'h72;
    rx_valid = 1'b1;
    ok = 1;
    repeat (50) begin
      @(negedge clk_48mhz);
      if (!(tx_valid === 1'b1 && tx_data === 8'h62 && rx_ready === 1'b0)) ok = 0;
    end
    check("stall_hold", 32'(ok), 32'd1);
    tx_ready = 1'b1;
    exp_q.push_back(8'h72);
    send_byte(8'h72);
    exp_q.push_back(8'h0D);
    send_byte(8'h0D);
    push_reply(K_OK);
    wait_idle("stall");
    check("stall_led", 32'(led), 32'b100);
    check("stall_cmd", 32'(cmd_cnt - c0), 32'd1);

    // reset while 'K' of an OK reply is on the bus
    exp_q.push_back(8'h67);
    send_byte(8'h67);
    exp_q.push_back(8'h0D);
    send_byte(8'h0D);
    push_reply(K_OK);
    found = 0;
    for (int t = 0; t < 200 && !found; t++) begin
      @(posedge clk_48mhz);
      #1;
      if (tx_valid && tx_data == 8'h4B) found = 1;
    end
    check("rstmid_found_k", 32'(found), 32'd1);
    tx_ready = 1'b0;
    reset    = 1'b1;
    @(posedge clk_48mhz);
    #1;
    reset = 1'b0;
    exp_q.delete();
    check("rstmid_tx_valid", 32'(tx_valid), 32'd0);
    check("rstmid_led", 32'(led), 32'd0);
    check("rstmid_rx_ready", 32'(rx_ready), 32'd1);
    tx_ready = 1'b1;
    run_line("post_rst", 160'("b"), 1, K_OK, 3'b001);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $fatal(1);
  end
endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
- Line-oriented command parser directly downstream of usb_uart's receive pipeline (uart_out_*); its transmit stream feeds usb_uart's uart_in_* pipeline.
- Echoes every received byte and collects a line of up to LINE_MAX characters.
- On carriage return, executes the line as a sequence of LED commands and sends back a short status reply.
- Replaces ad-hoc per-keystroke decoding in the FOMU top levels.

Parameters:
- LINE_MAX, 16, line buffer depth in bytes (2..64); counter width is clog2(LINE_MAX+1).

Ports:
- clk_48mhz  in  1  system clock, 48 MHz
- reset  in  1  synchronous, active-high reset
- rx_data  in  8  byte from usb_uart uart_out_data
- rx_valid  in  1  from uart_out_valid
- rx_ready  out  1  to uart_out_ready
- tx_data  out  8  to usb_uart uart_in_data
- tx_valid  out  1  to uart_in_valid
- tx_ready  in  1  from uart_in_ready
- led  out  3  LED state; bit2=r, bit1=g, bit0=b
- cmd_strobe  out  1  one-cycle pulse when a valid line is committed
- err_strobe  out  1  one-cycle pulse when a line is rejected

Behaviour:
- Clock and reset:
  - Single clock, clk_48mhz. Reset is synchronous and active-high on `reset`.
  - Reset values: led=0, tx_valid=0, tx_data=0, cmd_strobe=0, err_strobe=0, len=0, ovf=0, state=RECV.
- Handshake:
  - A transfer occurs on a clock edge where valid && ready.
  - tx_valid, once high, stays high and tx_data stays stable until tx_ready is seen.
  - rx_ready is decoded from state only (state==RECV). It never depends on rx_valid.
- States: RECV, ECHO, SCAN, COMMIT, REPLY.
- RECV:
  - rx_ready=1. On accept, latch the byte into cur.
  - LF (0x0A): discard, stay in RECV, no echo.
  - Any other byte: go to ECHO; tx_valid=1 and tx_data=cur on the next cycle.
  - Non-CR byte with len<LINE_MAX: buf[len]<=cur, len<=len+1.
  - Non-CR byte with len==LINE_MAX: not stored, ovf<=1, still echoed.
- ECHO: hold tx_valid until tx_ready.
  - Byte was CR: go to SCAN with idx=0 and shadow=led.
  - Otherwise: back to RECV.
  - Minimum RECV->RECV round trip is 2 cycles per byte.
- SCAN: one buffer entry per cycle (idx 0..len-1), applied to shadow in order:
  - 'r' toggles bit2; 'g' toggles bit1; 'b' toggles bit0; 'c' clears all bits.
  - Any other byte (including upper case) sets bad.
  - Go to COMMIT when idx==len. An empty line takes 0 scan cycles.
  - Latency CR-echo-accept -> COMMIT is len+1 cycles.
- COMMIT (1 cycle), reply selection:
  - len==0 and !ovf: no LED change, no strobe, reply "\n".
  - ovf or bad: led unchanged, err_strobe=1, reply "\nER\r\n".
  - Otherwise: led<=shadow, cmd_strobe=1, reply "\nOK\r\n".
  - Then clear len, ovf, bad; go to REPLY with ridx=0.
- REPLY:
  - Present reply bytes in order, one per tx handshake, never skipping or repeating.
  - After the last byte is accepted, return to RECV.
  - rx_ready=0 throughout SCAN, COMMIT and REPLY, so incoming bytes are back-pressured, not dropped.
- Boundary conditions:
  - Exactly LINE_MAX chars is valid. The LINE_MAX+1'th char sets ovf.
  - A CR arriving at len==LINE_MAX is still treated as terminator.
  - Buffer bytes at indices >= len are never read.
  - Reset mid-line or mid-reply: the line is discarded and tx_valid drops in the same cycle reset is sampled. Downstream usb_uart is reset by the same signal.
  - tx_ready high while tx_valid=0 is ignored.
  - LED outputs change only in COMMIT.

Test Plan:
- Send "r",CR with tx_ready=1 -> tx stream 'r',0x0D,0x0A,'O','K',0x0D,0x0A; led 000->100; one cmd_strobe pulse; no err_strobe.
- From led=100, send "gbc b",CR -> ' ' is illegal: tx "gbc b\r" + "\nER\r\n", led stays 100, one err_strobe. Then send "gbcb",CR -> led=001, cmd_strobe.
- Send 17 'g' then CR, LINE_MAX=16 -> all 17 echoed, reply "\nER\r\n", led unchanged. Exactly 16 'g' then CR -> OK, led unchanged (even toggles).
- Send CR alone, then LF -> tx 0x0D,0x0A only; LF produces no echo; no strobes.
- Hold tx_ready=0 for 50 cycles during the echo of 'b' -> tx_valid and tx_data='b' stable, rx_ready=0, second rx byte held off. Release -> sequence resumes with no loss.
- Assert reset for 1 cycle during the 'K' of a reply -> next cycle tx_valid=0, led=0, state RECV. A following "b",CR -> led=001 and the full OK reply.
